// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, RV32I opcode/funct constants and the
// decoded-entry record passed from the issue decoder to execute.
package alu_pkg;

  localparam int ALU_XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SUBU = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [3:0]          opr;
    logic [ALU_XLEN-1:0] op1;
    logic [ALU_XLEN-1:0] op2;
    logic [4:0]          rd;
    logic                illegal;
  } alu_entry_t;

  // alt selects SUB/SRA; callers only set it where the encoding permits
  function automatic logic [3:0] arith_opr(input logic [2:0] f3, input logic alt);
    logic [3:0] opr;
    case (f3)
      F3_ADD_SUB: opr = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     opr = ALU_SLL;
      F3_SLT:     opr = ALU_SLT;
      F3_SLTU:    opr = ALU_SLTU;
      F3_XOR:     opr = ALU_XOR;
      F3_SR:      opr = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      opr = ALU_OR;
      default:    opr = ALU_AND;
    endcase
    return opr;
  endfunction

endpackage

// File: rtl/alu_dec_fifo.sv
// Generic DEPTH-entry synchronous FIFO with registered occupancy count.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module alu_dec_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_decoder.sv
// RV32I -> ALU issue decoder with a small output FIFO between decode and execute.
// Optional ALU_DEC_STATS_EN adds issued/illegal statistics counters.
module alu_issue_decoder
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_opr,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [4:0]      rd,
  output logic            illegal
`ifdef ALU_DEC_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_illegal
`endif
);

  localparam int EW = $bits(alu_entry_t);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic            legal;
  alu_entry_t      dec;
  alu_entry_t      head;
  logic [EW-1:0]   fifo_rdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            push;
  logic            pop;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));

  // Anything not proven legal collapses to an all-zero ADD with illegal set
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        dec.rd  = instr[11:7];
        if (f7 == F7_BASE) begin
          legal   = 1'b1;
          dec.opr = arith_opr(f3, 1'b0);
        end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SR)) begin
          legal   = 1'b1;
          dec.opr = arith_opr(f3, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        dec.op1 = rs1_data;
        dec.op2 = imm_i;
        dec.rd  = instr[11:7];
        case (f3)
          F3_SLL:  legal = (f7 == F7_BASE);
          F3_SR:   legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
        dec.opr = arith_opr(f3, (f3 == F3_SR) && f7[5]);
      end
      OPC_BRANCH: begin
        dec.op1 = rs1_data;
        dec.op2 = rs2_data;
        case (f3)
          F3_BEQ, F3_BNE:   begin legal = 1'b1; dec.opr = ALU_SUB;  end
          F3_BLT, F3_BGE:   begin legal = 1'b1; dec.opr = ALU_SLT;  end
          F3_BLTU, F3_BGEU: begin legal = 1'b1; dec.opr = ALU_SLTU; end
          default:          legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        legal   = 1'b1;
        dec.opr = ALU_ADD;
        dec.op1 = rs1_data;
        dec.op2 = imm_i;
        dec.rd  = instr[11:7];
      end
      OPC_STORE: begin
        legal   = 1'b1;
        dec.opr = ALU_ADD;
        dec.op1 = rs1_data;
        dec.op2 = imm_s;
      end
      OPC_LUI: begin
        legal   = 1'b1;
        dec.opr = ALU_ADD;
        dec.op2 = imm_u;
        dec.rd  = instr[11:7];
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        dec.opr = ALU_ADD;
        dec.op1 = pc;
        dec.op2 = imm_u;
        dec.rd  = instr[11:7];
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready  = !fifo_full;
  assign out_valid = (fifo_count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_dec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (dec),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full)
  );

  // Stale storage behind an empty FIFO must never leak onto the payload
  assign head     = out_valid ? alu_entry_t'(fifo_rdata) : '0;
  assign alu_opr  = head.opr;
  assign operand1 = head.op1;
  assign operand2 = head.op2;
  assign rd       = head.rd;
  assign illegal  = head.illegal;

`ifdef ALU_DEC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else begin
      if (pop)                 stat_issued  <= stat_issued + 32'd1;
      if (push && dec.illegal) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed, table-driven bench for alu_issue_decoder: decode vectors, backpressure,
// mid-stream reset and (with ALU_DEC_STATS_EN) the statistics counters.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_opr;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  rd;
  logic        illegal;
`ifdef ALU_DEC_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_illegal;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_issue_decoder #(.DEPTH(2), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_opr   (alu_opr),
    .operand1  (operand1),
    .operand2  (operand2),
    .rd        (rd),
    .illegal   (illegal)
`ifdef ALU_DEC_STATS_EN
    ,
    .stat_issued  (stat_issued),
    .stat_illegal (stat_illegal)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  opr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;

  vec_t vq[$];

  task automatic addVec(input string n, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input logic il);
    vec_t v;
    v.name = n; v.instr = ins; v.pc = p; v.rs1 = r1; v.rs2 = r2;
    v.opr = o; v.op1 = a; v.op2 = b; v.rd = d; v.ill = il;
    vq.push_back(v);
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2, input logic v);
    instr    = ins;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = v;
  endtask

  task automatic checkOutput(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    else
      passes++;
  endtask

  task automatic checkPayload(input string n, input vec_t v);
    checkOutput({n, ".valid"},   32'(out_valid), 32'd1);
    checkOutput({n, ".opr"},     32'(alu_opr),   32'(v.opr));
    checkOutput({n, ".op1"},     operand1,       v.op1);
    checkOutput({n, ".op2"},     operand2,       v.op2);
    checkOutput({n, ".rd"},      32'(rd),        32'(v.rd));
    checkOutput({n, ".illegal"}, 32'(illegal),   32'(v.ill));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One instruction through an empty FIFO: push, check at N+1, drain
  task automatic runVec(input vec_t v);
    @(negedge clk);
    applyStimulus(v.instr, v.pc, v.rs1, v.rs2, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus('0, '0, '0, '0, 1'b0);
    checkPayload(v.name, v);
  endtask

  initial begin
    addVec("sub",      32'h40208033, 32'h0,    32'd7,        32'd3,  4'd1, 32'd7,        32'd3,        5'd0, 1'b0);
    addVec("addi",     32'h00500093, 32'h0,    32'd0,        32'd0,  4'd0, 32'd0,        32'd5,        5'd1, 1'b0);
    addVec("srai",     32'h4040D193, 32'h0,    32'h80000000, 32'd0,  4'd9, 32'h80000000, 32'h404,      5'd3, 1'b0);
    addVec("lui",      32'h123452B7, 32'h0,    32'h55,       32'h66, 4'd0, 32'd0,        32'h12345000, 5'd5, 1'b0);
    addVec("bad_opc",  32'h0000007F, 32'h40,   32'h55,       32'h66, 4'd0, 32'd0,        32'd0,        5'd0, 1'b1);
    addVec("or",       32'h0020E1B3, 32'h0,    32'hF0,       32'h0F, 4'd3, 32'hF0,       32'h0F,       5'd3, 1'b0);
    addVec("bad_f7",   32'h02208033, 32'h0,    32'd1,        32'd2,  4'd0, 32'd0,        32'd0,        5'd0, 1'b1);
    addVec("blt",      32'h0020C063, 32'h0,    32'd5,        32'd9,  4'd6, 32'd5,        32'd9,        5'd0, 1'b0);
    addVec("bgeu",     32'h0020F063, 32'h0,    32'd5,        32'd9,  4'd7, 32'd5,        32'd9,        5'd0, 1'b0);
    addVec("bad_br",   32'h0020A063, 32'h0,    32'd5,        32'd9,  4'd0, 32'd0,        32'd0,        5'd0, 1'b1);
    addVec("sw",       32'hFE20AE23, 32'h0,    32'h100,      32'h7,  4'd0, 32'h100,      32'hFFFFFFFC, 5'd0, 1'b0);
    addVec("auipc",    32'hABCDE397, 32'h1000, 32'h9,        32'h9,  4'd0, 32'h1000,     32'hABCDE000, 5'd7, 1'b0);
    addVec("bad_slli", 32'h02009093, 32'h0,    32'd1,        32'd0,  4'd0, 32'd0,        32'd0,        5'd0, 1'b1);
    addVec("lw",       32'hFFF12203, 32'h0,    32'h10,       32'd0,  4'd0, 32'h10,       32'hFFFFFFFF, 5'd4, 1'b0);
    addVec("bad_jal",  32'h0000006F, 32'h0,    32'd1,        32'd2,  4'd0, 32'd0,        32'd0,        5'd0, 1'b1);
    addVec("sltiu",    32'hFFF0B093, 32'h0,    32'd3,        32'd0,  4'd7, 32'd3,        32'hFFFFFFFF, 5'd1, 1'b0);

    rst_n = 1'b0;
    doReset();
    @(negedge clk);
    checkOutput("rst.in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.opr",       32'(alu_opr),   32'd0);
    checkOutput("rst.op1",       operand1,       32'd0);
    checkOutput("rst.op2",       operand2,       32'd0);

    for (int i = 0; i < vq.size(); i++) runVec(vq[i]);
    @(negedge clk);
    checkOutput("drain.out_valid", 32'(out_valid), 32'd0);
    checkOutput("drain.op2",       operand2,       32'd0);

    // Backpressure: A,B fill the FIFO, C waits; release and pop in order
    out_ready = 1'b0;
    applyStimulus(32'h00100093, '0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("bp.a_valid",  32'(out_valid), 32'd1);
    checkOutput("bp.a_op2",    operand2,       32'd1);
    checkOutput("bp.ready1",   32'(in_ready),  32'd1);
    applyStimulus(32'h00200093, '0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("bp.full",     32'(in_ready),  32'd0);
    checkOutput("bp.hold1",    operand2,       32'd1);
    applyStimulus(32'h00300093, '0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("bp.full2",    32'(in_ready),  32'd0);
    checkOutput("bp.hold2",    operand2,       32'd1);
    checkOutput("bp.hold_rd",  32'(rd),        32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.b_op2",    operand2,       32'd2);
    checkOutput("bp.ready2",   32'(in_ready),  32'd1);
    @(negedge clk);
    applyStimulus('0, '0, '0, '0, 1'b0);
    checkOutput("bp.c_valid",  32'(out_valid), 32'd1);
    checkOutput("bp.c_op2",    operand2,       32'd3);
    @(negedge clk);
    checkOutput("bp.empty",    32'(out_valid), 32'd0);
    checkOutput("bp.empty_op", operand2,       32'd0);

    // Reset with two entries queued
    out_ready = 1'b0;
    applyStimulus(32'h00700093, '0, '0, '0, 1'b1);
    @(negedge clk);
    applyStimulus(32'h00800093, '0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("mr.full", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mr.out_valid", 32'(out_valid), 32'd0);
    checkOutput("mr.in_ready",  32'(in_ready),  32'd1);
    checkOutput("mr.op2",       operand2,       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mr.post_ready", 32'(in_ready),  32'd1);
    checkOutput("mr.post_valid", 32'(out_valid), 32'd0);
    runVec(vq[0]);

`ifdef ALU_DEC_STATS_EN
    doReset();
    @(negedge clk);
    checkOutput("st.rst_issued",  stat_issued,  32'd0);
    checkOutput("st.rst_illegal", stat_illegal, 32'd0);
    runVec(vq[0]);
    runVec(vq[4]);
    runVec(vq[1]);
    runVec(vq[6]);
    runVec(vq[2]);
    @(negedge clk);
    checkOutput("st.issued",  stat_issued,  32'd5);
    checkOutput("st.illegal", stat_illegal, 32'd2);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
